// File: rtl/palette_pkg.sv
// Shared types and constants for the palette quantizer and colour-compare blocks.
package palette_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} pq_state_t;

    localparam int unsigned DIST_W = 6;
    localparam logic [DIST_W-1:0] DIST_INIT = 6'd63;

    function automatic logic [3:0] abs_diff4(input logic [3:0] x, input logic [3:0] y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/color_dist.sv
// Manhattan distance between two 12-bit RGB colours, 0..45.
module color_dist
    import palette_pkg::*;
(
    input  rgb12_t            a,
    input  rgb12_t            b,
    output logic [DIST_W-1:0] d
);

    always_comb begin
        d = DIST_W'(abs_diff4(a.r, b.r)) + DIST_W'(abs_diff4(a.g, b.g))
          + DIST_W'(abs_diff4(a.b, b.b));
    end

endmodule

// File: rtl/palette_quantizer.sv
// Nearest-entry search of a 12-bit RGB colour against a loadable palette,
// one entry per cycle, with valid/ready handshakes on both sides.
module palette_quantizer
    import palette_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pal_we,
    input  logic [IDX_W-1:0]  pal_addr,
    input  logic [11:0]       pal_data,
    output logic              pal_busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [11:0]       in_rgb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [DIST_W-1:0] out_dist
);

    localparam int unsigned N = 1 << IDX_W;
    localparam logic [IDX_W-1:0] CNT_MAX = IDX_W'(N - 1);

    pq_state_t         state;
    rgb12_t            pal [N];
    rgb12_t            rgb_q;
    logic [IDX_W-1:0]  cnt;
    logic [DIST_W-1:0] best_dist;
    logic [IDX_W-1:0]  best_idx;

    logic [DIST_W-1:0] d;
    logic [DIST_W-1:0] nxt_dist;
    logic [IDX_W-1:0]  nxt_idx;
    logic              last;

    color_dist u_dist (
        .a (rgb_q),
        .b (pal[cnt]),
        .d (d)
    );

    // Strict compare keeps the lower index on ties.
    always_comb begin
        nxt_dist = best_dist;
        nxt_idx  = best_idx;
        if (d < best_dist) begin
            nxt_dist = d;
            nxt_idx  = cnt;
        end
        last = (d == '0) || (cnt == CNT_MAX);
    end

    assign in_ready = (state == IDLE);
    assign pal_busy = (state != IDLE);

    // Reset image is a grey ramp; deeper palettes repeat it.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < N; i++) begin
                pal[i] <= {i[3:0], i[3:0], i[3:0]};
            end
        end else if (pal_we && state == IDLE) begin
            pal[pal_addr] <= pal_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= IDLE;
            rgb_q     <= '0;
            cnt       <= '0;
            best_dist <= DIST_INIT;
            best_idx  <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_dist  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        rgb_q     <= in_rgb;
                        cnt       <= '0;
                        best_dist <= DIST_INIT;
                        best_idx  <= '0;
                        state     <= SEARCH;
                    end
                end
                SEARCH: begin
                    best_dist <= nxt_dist;
                    best_idx  <= nxt_idx;
                    if (last) begin
                        out_valid <= 1'b1;
                        out_index <= nxt_idx;
                        out_dist  <= nxt_dist;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_palette_quantizer.sv
// Directed self-checking bench for palette_quantizer (IDX_W = 4, 16 entries).
module tb_palette_quantizer;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [11:0] pal_data;
    logic        pal_busy;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_rgb;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_index;
    logic [5:0]  out_dist;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;

    palette_quantizer #(.IDX_W(4)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .pal_we    (pal_we),
        .pal_addr  (pal_addr),
        .pal_data  (pal_data),
        .pal_busy  (pal_busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rgb    (in_rgb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_dist  (out_dist)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pal_write(input logic [3:0] addr, input logic [11:0] data);
        pal_we   = 1'b1;
        pal_addr = addr;
        pal_data = data;
        tick();
        pal_we   = 1'b0;
    endtask

    // Latency counts edges from the input handshake edge T (which counts as 1).
    task automatic start_query(input logic [11:0] rgb);
        in_rgb   = rgb;
        in_valid = 1'b1;
        tick();
        t0       = cyc - 1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp_idx, input int exp_dist,
                               input int exp_lat);
        while (!out_valid && (cyc - t0) < 60) tick();
        check_eq({tag, "_lat"}, cyc - t0, exp_lat);
        check_eq({tag, "_idx"}, out_index, exp_idx);
        check_eq({tag, "_dist"}, out_dist, exp_dist);
    endtask

    // Assumes out_ready is already high.
    task automatic consume(input string tag);
        tick();
        check_eq({tag, "_drop"}, out_valid, 0);
        check_eq({tag, "_ready"}, in_ready, 1);
    endtask

    task automatic query(input string tag, input logic [11:0] rgb, input int exp_idx,
                         input int exp_dist, input int exp_lat);
        start_query(rgb);
        wait_result(tag, exp_idx, exp_dist, exp_lat);
        consume(tag);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
    endtask

    initial begin
        int bad;
        Reset_n   = 1'b0;
        pal_we    = 1'b0;
        pal_addr  = '0;
        pal_data  = '0;
        in_valid  = 1'b0;
        in_rgb    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        Reset_n = 1'b1;

        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_index", out_index, 0);
        check_eq("rst_dist", out_dist, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_busy", pal_busy, 0);

        // Exact grey match at k = 5, then full search with worst-case red.
        query("q555", 12'h555, 5, 0, 7);
        query("qF00", 12'hF00, 0, 15, 17);

        // Tie at distance 1 between entries 3 and 9; lower index wins.
        pal_write(4'd3, 12'hA00);
        pal_write(4'd9, 12'hA00);
        query("tie", 12'hB00, 3, 1, 17);
        query("qA00", 12'hA00, 3, 0, 5);

        // Backpressure: hold out_ready low, poke in_valid, outputs must freeze.
        out_ready = 1'b0;
        start_query(12'h777);
        check_eq("search_busy", pal_busy, 1);
        check_eq("search_in_ready", in_ready, 0);
        wait_result("bp", 7, 0, 9);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            in_rgb   = 12'($urandom);
            tick();
            if (out_valid !== 1'b1 || out_index !== 4'd7 || out_dist !== 6'd0 ||
                in_ready !== 1'b0)
                bad++;
        end
        in_valid = 1'b0;
        check_eq("bp_stable", bad, 0);
        out_ready = 1'b1;
        consume("bp");
        check_eq("bp_keep_idx", out_index, 7);
        tick();
        tick();
        check_eq("bp_no_new_query", pal_busy, 0);

        // Palette writes during SEARCH are dropped.
        do_reset();
        start_query(12'hFFF);
        tick();
        tick();
        pal_write(4'd0, 12'hF00);
        wait_result("ignw", 15, 0, 17);
        consume("ignw");
        query("ignw_chk", 12'hF00, 0, 15, 17);

        // Write and query in the same IDLE cycle: search sees the new entry.
        pal_we   = 1'b1;
        pal_addr = 4'd0;
        pal_data = 12'hF00;
        start_query(12'hF00);
        pal_we = 1'b0;
        wait_result("wq", 0, 0, 2);
        consume("wq");

        // Reset mid-SEARCH discards the query and restores the grey ramp.
        start_query(12'hFFF);
        tick();
        tick();
        do_reset();
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_ready", in_ready, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        check_eq("mid_rst_no_valid", bad, 0);
        query("post_rst555", 12'h555, 5, 0, 7);
        query("post_rstF00", 12'hF00, 0, 15, 17);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/palette_quantizer.md
Name: palette_quantizer

Overview:
- Inverse of the sprite/background palette lookups: takes a 12-bit RGB colour and returns the index of the nearest entry in a loadable 2^IDX_W-entry palette.
- Used when converting captured or generated RGB pixels (menu/title effects, screenshot-to-sprite RAM) back into indexed form for the existing ROM/palette pipeline.
- Sequential search, one palette entry per cycle, with a valid/ready handshake on both sides.

Parameters:
IDX_W, 4, index width; palette depth N = 2^IDX_W (legal 2..6)

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous active-low reset
pal_we  in  1  palette write strobe (honoured only in IDLE)
pal_addr  in  IDX_W  palette entry to write
pal_data  in  12  {red,green,blue}, 4 bits each
pal_busy  out  1  high when not IDLE (writes ignored)
in_valid  in  1  query colour valid
in_ready  out  1  high in IDLE
in_rgb  in  12  query colour {red,green,blue}
out_valid  out  1  result valid, held until accepted
out_ready  in  1  consumer accepts result
out_index  out  IDX_W  nearest palette index
out_dist  out  6  Manhattan distance |dr|+|dg|+|db|, 0..45

Behaviour:
- Clock/reset: single clock Clk; Reset_n synchronous active-low. Reset applies regardless of state.
- Reset values:
  - state = IDLE; out_valid = 0; out_index = 0; out_dist = 0.
  - Palette entry i = {i[3:0], i[3:0], i[3:0]}, a grey ramp. For IDX_W > 4, i[3:0] wraps.
- States:
  - IDLE: in_ready = 1; pal_busy = 0.
    - pal_we writes pal_data to entry pal_addr at the clock edge.
    - On in_valid: latch in_rgb, set cnt = 0, best_dist = 63, best_idx = 0, and go to SEARCH.
    - If pal_we and in_valid occur in the same cycle, both take effect; the search sees the new entry.
  - SEARCH: in_ready = 0; pal_busy = 1.
    - Each cycle, compute d = dist(rgb, palette[cnt]).
    - If d < best_dist (strict), register best = (d, cnt). On ties the lower index wins.
    - If d == 0 or cnt == N-1, go to DONE with the updated best; otherwise increment cnt.
    - pal_we is ignored.
  - DONE: out_valid = 1; out_index and out_dist hold best_idx and best_dist, stable until out_ready.
    - When out_valid && out_ready, go to IDLE; out_valid drops the next cycle. out_index and out_dist retain their last values.
    - in_ready = 0. No new query is accepted in the same cycle as the output handshake.
- Latency: the input handshake occurs at edge T.
  - Exact match at entry k: out_valid is first high in cycle T+k+2.
  - No exact match: out_valid is first high in cycle T+N+1.
  - Throughput is one query per (latency + 1) cycles minimum.
- Arithmetic:
  - Each channel difference is the 4-bit unsigned absolute value.
  - The sum is zero-extended to 6 bits; no overflow is possible (maximum 45).
  - cnt is IDX_W bits and never wraps, because the terminal check precedes the increment.
- Boundary conditions:
  - out_ready held low: remain in DONE indefinitely with outputs frozen.
  - in_valid while not IDLE: not accepted; in_rgb may change freely.
  - Reset mid-SEARCH or mid-DONE: out_valid = 0 the next cycle, the palette returns to the grey ramp, and the pending query is discarded.
  - out_ready high in IDLE or SEARCH: no effect.

Decomposition:
- Shared package palette_pkg:
  - typedef rgb12_t, a packed struct {logic [3:0] r, g, b}.
  - enum pq_state_t {IDLE, SEARCH, DONE}.
  - localparam DIST_W = 6 and localparam DIST_INIT = 6'd63.
- Sub-module color_dist: purely combinational; inputs rgb12_t a and b; output [5:0] d. Reusable by other colour-compare blocks.
- Palette storage is a register array inside palette_quantizer; it is not RAM, because it has a reset image.

Test Plan:
- Reset, then query {5,5,5}, out_ready = 1 → out_index 5, out_dist 0, out_valid first high at T+7 (early exit at k = 5).
- Query {F,0,0} on the reset palette → entry i has distance 15+i, so the result is out_index 0, out_dist 15, out_valid at T+17 (full search).
- Write entries 3 and 9 = {A,0,0} in IDLE, then query {B,0,0} → tie at distance 1, so out_index 3, out_dist 1; out_valid at T+17. Then query {A,0,0} → index 3, distance 0, out_valid at T+5.
- Backpressure: hold out_ready = 0 for 20 cycles after out_valid → outputs stable, in_ready = 0, in_valid pulses ignored; raise out_ready → one handshake, in_ready = 1 the next cycle.
- pal_we to entry 0 with {F,0,0} during SEARCH is ignored → a later query {F,0,0} returns index 0, distance 15, not distance 0. The same write plus in_valid in IDLE → distance 0, index 0, out_valid at T+2.
- Assert Reset_n = 0 for one cycle mid-SEARCH → no out_valid for that query; the palette returns to the grey ramp; the next query {5,5,5} behaves as in the first scenario.
